countdown_timer: RTL
====================

# countdown_timer

Loadable 10-bit down-counter for the MAX10 board, the countdown counterpart of the board's up-counter exercise. KEY[1] is debounced and loads the switch value. The count then decrements at a divided tick rate, shown on LEDR, until it reaches zero. At zero it stops and raises `done`. The block doubles as a testbench target for load, tick and terminal-count behaviour.

## Interface
- CLK_DIV, 10: system clocks per decrement tick (5 MHz at 50 MHz); legal ≥ 2
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks before a KEY[1] change is accepted (10 ms); legal ≥ 1
- MAX10_CLK1_50  input  1  the only clock, rising edge
- KEY  input  2  KEY[0]: reset, asynchronous, active-low, highest priority; KEY[1]: load/start button, active-low, asynchronous to clock
- SW  input  10  load value, sampled on the load edge only
- LEDR  output  10  current count
- done  output  1  high while the count is stopped at terminal zero

## Operation
- Reset (KEY[0]=0): state IDLE, LEDR=0, done=0, tick counter=0, sync/debounce flops=1 (released), debounce counter=0.
- KEY[1] path: 2-flop synchronizer, then debounce. The debounced level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive clocks; any agreeing clock clears the counter. A press is a 1→0 transition of the debounced level and produces a one-cycle `press` pulse. Release produces no event. A held button produces exactly one press.
- FSM states: IDLE, RUN, DONE.
  - IDLE: LEDR=0, done=0. On press: LEDR←SW, tick counter←0, go to RUN. If SW=0, go to DONE instead.
  - RUN: on tick, if LEDR≠1 then LEDR←LEDR−1. If LEDR=1, then LEDR←0, done←1, go to DONE. A press in RUN reloads: LEDR←SW, tick counter←0, stay in RUN (DONE if SW=0).
  - DONE: LEDR holds 0, done=1. On press: reload exactly as from IDLE, and done←0 on the same edge unless SW=0.
- Tick: a free counter runs 0..CLK_DIV−1 in RUN only, and is cleared on every load. The tick pulse is one cycle wide, asserted when the counter equals CLK_DIV−1. Outside RUN the counter is held at 0.
- Press and tick on the same edge: the press wins. Reload happens and the tick is discarded.
- No wrap-around: the count never decrements below 0.
- SW changes outside the load edge have no effect.

## Timing
- KEY[1] falls and stays stable, first sampled low at edge k: the debounced level falls at edge k+1+DEBOUNCE_CYCLES, `press` is high for the following cycle, and LEDR shows SW after edge k+2+DEBOUNCE_CYCLES (load edge L).
- First decrement at edge L+CLK_DIV. Each subsequent decrement follows CLK_DIV clocks after the previous one.
- Loaded value N≥1: LEDR reaches 0 and done rises at edge L+N·CLK_DIV.
- done and LEDR are registered outputs with no combinational path from inputs.
- Reset mid-count: outputs go to their reset values asynchronously. After KEY[0] returns high, the block waits for a fresh press, even if KEY[1] is already held low. This works because the debounce flops reset to released, so a held key produces a new press after the debounce delay.

## Structure
- Shared package: COUNT_W=10; state encoding constants ST_IDLE/ST_RUN/ST_DONE; default CLK_DIV and DEBOUNCE_CYCLES.
- Sub-module `key_debounce`:
  - ports: clock, reset, raw active-low key, outputs debounced level and press pulse
  - parameter: DEBOUNCE_CYCLES
  - reused later for other KEY inputs
- Top holds the tick divider, the FSM and the count register. Counter widths use $clog2 of the parameters.

## Test plan
All scenarios use CLK_DIV=4 and DEBOUNCE_CYCLES=3.
- Reset: KEY[0]=0 mid-RUN with LEDR=0x12 → LEDR=0 and done=0 immediately, without a clock edge; the block stays IDLE after release until a new press.
- Basic countdown: SW=5, press held → LEDR=5 at edge L, then 4,3,2,1,0 at L+4, L+8, L+12, L+16, L+20; done=1 at L+20; LEDR stays 0 for a further 40 clocks.
- Bounce: KEY[1] toggles every 2 clocks for 20 clocks, then stays low → exactly one load, occurring 5 clocks after the last toggle's first low sample; no load during toggling.
- Reload in RUN: SW=0x3FF loaded, after 3 ticks set SW=7 and press again → LEDR=7, tick phase restarts, done=1 exactly 28 clocks after the reload edge.
- Zero load and DONE reload: SW=0, press → DONE immediately, with done=1 and no ticks. Then SW=2, press → done=0 and LEDR=2 on the load edge, and done=1 again 8 clocks later.
- Hold and collision: KEY[1] held low for 100 clocks after SW=3 → a single load, and done=1 at L+12. Separately, a press aligned with a tick edge → reload wins and the count is not decremented.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and its key debouncer.
package countdown_timer_pkg;

    localparam int unsigned COUNT_W                 = 10;
    localparam int unsigned CLK_DIV_DEFAULT         = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low push button; emits a one-cycle pulse on press.
module key_debounce
    import countdown_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_ni;
            sync2_q <= sync1_q;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state and registered press pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: KEY[1] loads SW, count decrements every CLK_DIV clocks to zero.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV         = CLK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               MAX10_CLK1_50,
    input  logic [1:0]         KEY,
    input  logic [COUNT_W-1:0] SW,
    output logic [COUNT_W-1:0] LEDR,
    output logic               done
);

    localparam int unsigned TICK_W = $clog2(CLK_DIV);

    logic               rst_n;
    logic               key_level;
    logic               press;
    logic               load;
    logic               tick;
    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q, done_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;

    assign rst_n = KEY[0];

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i  (MAX10_CLK1_50),
        .rst_ni (rst_n),
        .key_ni (KEY[1]),
        .level_o(key_level),
        .press_o(press)
    );

    // A press pulse always coincides with the debounced key being down.
    assign load = press & ~key_level;
    assign tick = (state_q == ST_RUN) && (tick_cnt_q == TICK_W'(CLK_DIV - 1));

    // Next-state logic: load has priority over tick in every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        tick_cnt_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                done_d  = 1'b0;
            end
            ST_RUN: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
                if (tick) begin
                    if (count_q <= COUNT_W'(1)) begin
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - COUNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                count_d = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                done_d  = 1'b0;
            end
        endcase
        if (load) begin
            count_d    = SW;
            tick_cnt_d = '0;
            if (SW == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end
        end
    end

    // State, count, done and tick divider registers.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign LEDR = count_q;
    assign done = done_q;

endmodule
